collatz_sweep: RTL and testbench

COLLATZ_SWEEP -- requirements
Module: collatz_sweep

---
 rtl/collatz_sweep.sv | 153 +++++++++++++++
 tb/tb_collatz_sweep.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/collatz_sweep.sv
// collatz_sweep: sweeps `count` consecutive start values beginning at `base`
// through an external Collatz iterator core, storing each value's step count
// in a small result RAM and tracking the start value with the longest run.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start with a non-zero count
// LOAD   | strobe core with base+idx, or bypass a zero value
// RUN    | count core steps until done, step limit or 3n+1 overflow
// STORE  | write result to RAM[idx], update running maximum
// FINISH | one-cycle done pulse, back to IDLE
module collatz_sweep #(
  parameter int AW        = 6,
  parameter int CW        = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [31:0]   base,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic [31:0]   max_start,
  output logic [CW-1:0] max_steps,
  output logic          err,
  input  logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_data,
  output logic          core_go,
  output logic [31:0]   core_n,
  input  logic [31:0]   core_dout,
  input  logic          core_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_STORE,
    S_FINISH
  } state_t;

  state_t state, state_nx;

  logic [31:0]   base_r;
  logic [AW:0]   count_r;
  logic [AW:0]   idx;
  logic [AW:0]   idx_inc;
  logic [CW-1:0] step_cnt;
  logic [CW-1:0] result;
  logic          first_run;
  logic          val_zero;
  logic          run_done;
  logic          ovf;
  logic          at_limit;
  logic          accept;
  logic [CW-1:0] mem [0:(1<<AW)-1];

  assign core_n   = base_r + 32'(idx);
  assign idx_inc  = idx + {{AW{1'b0}}, 1'b1};
  assign val_zero = (core_n == 32'd0);
  // The core may still show a stale done from the previous value right after a load.
  assign run_done = !first_run && core_done;
  assign ovf      = core_dout[0] && (core_dout > 32'h5555_5554);
  assign at_limit = (step_cnt == CW'(MAX_STEPS));
  assign accept   = (state == S_IDLE) && start && (count != '0);

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_FINISH);
  assign core_go = (state == S_LOAD) && !val_zero;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = S_LOAD;
      S_LOAD:   state_nx = val_zero ? S_STORE : S_RUN;
      S_RUN:    if (run_done || ovf || at_limit) state_nx = S_STORE;
      S_STORE:  state_nx = (idx_inc < count_r) ? S_LOAD : S_FINISH;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Sweep datapath: capture, step counting, result and running maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r    <= '0;
      count_r   <= '0;
      idx       <= '0;
      step_cnt  <= '0;
      result    <= '0;
      first_run <= 1'b0;
      err       <= 1'b0;
      max_start <= '0;
      max_steps <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            base_r    <= base;
            count_r   <= count;
            idx       <= '0;
            err       <= 1'b0;
            max_start <= '0;
            max_steps <= '0;
          end
        end
        S_LOAD: begin
          step_cnt  <= '0;
          first_run <= 1'b1;
          if (val_zero) begin
            result <= '1;
            err    <= 1'b1;
          end
        end
        S_RUN: begin
          first_run <= 1'b0;
          if (run_done) begin
            result <= step_cnt;
          end else if (ovf || at_limit) begin
            result <= '1;
            err    <= 1'b1;
          end else if (core_dout != 32'd1) begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        S_STORE: begin
          // Strict compare keeps the earlier (lower) start value on ties.
          if ((result != '1) && (result > max_steps)) begin
            max_start <= core_n;
            max_steps <= result;
          end
          if (idx_inc < count_r) idx <= idx_inc;
        end
        default: ;
      endcase
    end
  end

  // Result RAM: not reset; registered read returns old data on a same-address write.
  always_ff @(posedge clk) begin
    if (state == S_STORE) mem[idx[AW-1:0]] <= result;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_collatz_sweep.sv
// tb_collatz_sweep: directed bench for collatz_sweep with a behavioural
// Collatz iterator core; a second instance uses a 100-step limit.
module tb_collatz_sweep;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [6:0]  count = '0;
  logic [5:0]  rd_addr = '0;

  logic        busy, done, err, core_go, core_done;
  logic [31:0] max_start, core_n;
  logic [15:0] max_steps, rd_data;
  logic [31:0] core_dout = 32'd1;

  logic        busy2, done2, err2, core_go2, core_done2;
  logic [31:0] max_start2, core_n2;
  logic [15:0] max_steps2, rd_data2;
  logic [31:0] core_dout2 = 32'd1;

  int n_cmp = 0;
  int n_err = 0;
  int dcount = 0;
  int gocount = 0;

  always #5 clk = ~clk;

  collatz_sweep dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .count(count),
    .busy(busy), .done(done), .max_start(max_start), .max_steps(max_steps),
    .err(err), .rd_addr(rd_addr), .rd_data(rd_data), .core_go(core_go),
    .core_n(core_n), .core_dout(core_dout), .core_done(core_done)
  );

  collatz_sweep #(.MAX_STEPS(100)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .count(count),
    .busy(busy2), .done(done2), .max_start(max_start2), .max_steps(max_steps2),
    .err(err2), .rd_addr(rd_addr), .rd_data(rd_data2), .core_go(core_go2),
    .core_n(core_n2), .core_dout(core_dout2), .core_done(core_done2)
  );

  // Iterator core models: load on go, otherwise one Collatz step per cycle until 1.
  assign core_done  = (core_dout == 32'd1);
  assign core_done2 = (core_dout2 == 32'd1);

  always @(posedge clk) begin
    if (core_go) core_dout <= core_n;
    else if (core_dout != 32'd1 && core_dout != 32'd0)
      core_dout <= core_dout[0] ? (core_dout * 32'd3 + 32'd1) : (core_dout >> 1);
  end

  always @(posedge clk) begin
    if (core_go2) core_dout2 <= core_n2;
    else if (core_dout2 != 32'd1 && core_dout2 != 32'd0)
      core_dout2 <= core_dout2[0] ? (core_dout2 * 32'd3 + 32'd1) : (core_dout2 >> 1);
  end

  // Event counters sampled away from the active edge.
  always @(negedge clk) begin
    if (done) dcount++;
    if (core_go) gocount++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [31:0] b, input logic [6:0] c);
    @(negedge clk);
    base = b; count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_reached", {63'd0, done}, 64'd1);
  endtask

  task automatic rd(input logic [5:0] a, output logic [15:0] v1, output logic [15:0] v2);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    v1 = rd_data;
    v2 = rd_data2;
  endtask

  initial begin
    int cyc;
    int d0, g0;
    logic [15:0] v1, v2;

    // Reset state
    #3;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_core_go", {63'd0, core_go}, 64'd0);
    chk("rst_core_n", {32'd0, core_n}, 64'd0);
    chk("rst_max_start", {32'd0, max_start}, 64'd0);
    chk("rst_max_steps", {48'd0, max_steps}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // base=6, count=1
    d0 = dcount;
    go(32'd6, 7'd1);
    chk("t6_busy_after_accept", {63'd0, busy}, 64'd1);
    wait_done(cyc);
    chk("t6_latency", 64'(cyc), 64'd12);
    repeat (3) @(negedge clk);
    chk("t6_busy_idle", {63'd0, busy}, 64'd0);
    chk("t6_done_pulses", 64'(dcount - d0), 64'd1);
    chk("t6_max_start", {32'd0, max_start}, 64'd6);
    chk("t6_max_steps", {48'd0, max_steps}, 64'd8);
    chk("t6_err", {63'd0, err}, 64'd0);
    rd(6'd0, v1, v2);
    chk("t6_ram0", {48'd0, v1}, 64'd8);

    // count=0 is ignored
    d0 = dcount;
    go(32'd9, 7'd0);
    chk("c0_busy", {63'd0, busy}, 64'd0);
    repeat (5) @(negedge clk);
    chk("c0_no_done", 64'(dcount - d0), 64'd0);

    // base=1, count=4
    go(32'd1, 7'd4);
    wait_done(cyc);
    chk("t1_max_start", {32'd0, max_start}, 64'd3);
    chk("t1_max_steps", {48'd0, max_steps}, 64'd7);
    chk("t1_err", {63'd0, err}, 64'd0);
    rd(6'd0, v1, v2); chk("t1_ram0", {48'd0, v1}, 64'd0);
    rd(6'd1, v1, v2); chk("t1_ram1", {48'd0, v1}, 64'd1);
    rd(6'd2, v1, v2); chk("t1_ram2", {48'd0, v1}, 64'd7);
    rd(6'd3, v1, v2); chk("t1_ram3", {48'd0, v1}, 64'd2);

    // tie: 12 and 13 both take 9 steps, lower start wins
    go(32'd12, 7'd2);
    wait_done(cyc);
    chk("tie_max_start", {32'd0, max_start}, 64'd12);
    chk("tie_max_steps", {48'd0, max_steps}, 64'd9);
    rd(6'd1, v1, v2); chk("tie_ram1", {48'd0, v1}, 64'd9);

    // base=27: 111 steps with limit 1000, abort with limit 100
    go(32'd27, 7'd1);
    wait_done(cyc);
    chk("t27_max_steps", {48'd0, max_steps}, 64'd111);
    chk("t27_err", {63'd0, err}, 64'd0);
    chk("t27_lim_err", {63'd0, err2}, 64'd1);
    chk("t27_lim_max_steps", {48'd0, max_steps2}, 64'd0);
    rd(6'd0, v1, v2);
    chk("t27_ram0", {48'd0, v1}, 64'd111);
    chk("t27_lim_ram0", {48'd0, v2}, 64'hFFFF);

    // base=FFFFFFFF, count=2: overflow abort then zero bypass
    g0 = gocount;
    go(32'hFFFF_FFFF, 7'd2);
    wait_done(cyc);
    chk("ovf_core_go_count", 64'(gocount - g0), 64'd1);
    chk("ovf_err", {63'd0, err}, 64'd1);
    chk("ovf_max_steps", {48'd0, max_steps}, 64'd0);
    chk("ovf_max_start", {32'd0, max_start}, 64'd0);
    rd(6'd0, v1, v2); chk("ovf_ram0", {48'd0, v1}, 64'hFFFF);
    rd(6'd1, v1, v2); chk("ovf_ram1", {48'd0, v1}, 64'hFFFF);

    // reset during RUN of a count=8 sweep
    d0 = dcount;
    go(32'd6, 7'd8);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_core_go", {63'd0, core_go}, 64'd0);
    chk("mid_rst_core_n", {32'd0, core_n}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    chk("mid_rst_no_done", 64'(dcount - d0), 64'd0);
    chk("mid_rst_idle", {63'd0, busy}, 64'd0);
    go(32'd6, 7'd1);
    wait_done(cyc);
    chk("post_rst_max_steps", {48'd0, max_steps}, 64'd8);
    rd(6'd0, v1, v2); chk("post_rst_ram0", {48'd0, v1}, 64'd8);

    // start held high through the sweep: base=5, count=2
    d0 = dcount;
    @(negedge clk);
    base = 32'd5; count = 7'd2; start = 1'b1;
    @(negedge clk);
    wait_done(cyc);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold_done_pulses", 64'(dcount - d0), 64'd1);
    chk("hold_max_start", {32'd0, max_start}, 64'd6);
    chk("hold_max_steps", {48'd0, max_steps}, 64'd8);
    rd(6'd0, v1, v2); chk("hold_ram0", {48'd0, v1}, 64'd5);
    rd(6'd1, v1, v2); chk("hold_ram1", {48'd0, v1}, 64'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
